// File: rtl/bist_sched_pkg.sv
// Shared types and sizing helpers for the MBIST session scheduler.
package bist_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN   = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  // Inter-session gap counter width; bounds GAP to 2**GAP_CNT_W.
  localparam int unsigned GAP_CNT_W = 8;

  // Width of an instance index for n SRAM instances.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bist_sched_if.sv
// Sweep control, engine handshake and result bus of the MBIST scheduler.
interface bist_sched_if
  import bist_sched_pkg::*;
#(
  parameter int unsigned NUM_MEM = 4
);
  localparam int unsigned IDX_W = idx_w(NUM_MEM);

  logic               start;
  logic [NUM_MEM-1:0] mem_mask;
  logic               eng_start;
  logic               eng_done;
  logic               eng_pass;
  logic [IDX_W-1:0]   mem_sel;
  logic               busy;
  logic               done;
  logic [NUM_MEM-1:0] fail_map;
  logic               all_pass;
  logic [NUM_MEM-1:0] timeout_map;

  // Environment side: sweep requester plus BIST engine.
  modport master (
    output start, mem_mask, eng_done, eng_pass,
    input  eng_start, mem_sel, busy, done, fail_map, all_pass, timeout_map
  );

  // Scheduler side.
  modport slave (
    input  start, mem_mask, eng_done, eng_pass,
    output eng_start, mem_sel, busy, done, fail_map, all_pass, timeout_map
  );

endinterface

// File: rtl/bist_sched_pick.sv
// Picks the lowest enabled instance index at or above base.
module bist_sched_pick
  import bist_sched_pkg::*;
#(
  parameter int unsigned NUM_MEM = 4,
  parameter int unsigned IDX_W   = idx_w(NUM_MEM)
) (
  input  logic [NUM_MEM-1:0] mask_i,
  input  logic [IDX_W-1:0]   base_i,
  output logic               found_c,
  output logic [IDX_W-1:0]   idx_c
);

  // Scan downward so the lowest qualifying index is the last one written.
  always_comb begin
    found_c = 1'b0;
    idx_c   = '0;
    for (int i = NUM_MEM - 1; i >= 0; i--) begin
      if (mask_i[i] && (IDX_W'(i) >= base_i)) begin
        found_c = 1'b1;
        idx_c   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/bist_sched.sv
// Time-shares one MBIST engine across NUM_MEM SRAM instances, in ascending
// index order, recording per-instance pass/fail.
// Optional per-session watchdog: define BIST_SCHED_TIMEOUT_EN.
module bist_sched
  import bist_sched_pkg::*;
#(
  parameter int unsigned NUM_MEM = 4,
  parameter int unsigned GAP     = 2,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  bist_sched_if.slave bus
);

  localparam int unsigned IDX_W = idx_w(NUM_MEM);

  // Reject parameter sets the counters and index width cannot represent.
  if (NUM_MEM < 2 || NUM_MEM > 16 || GAP < 1 || GAP > (1 << GAP_CNT_W) ||
      TIMEOUT < 2) begin : g_bad_params
    $error("bist_sched: illegal parameter set");
  end

  state_e                 state_q, state_d;
  logic [NUM_MEM-1:0]     mask_q, mask_d;
  logic [IDX_W-1:0]       base_q, base_d;
  logic [IDX_W-1:0]       sel_q, sel_d;
  logic                   eng_q, eng_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [NUM_MEM-1:0]     fail_q, fail_d;
  logic                   allp_q;
  logic [GAP_CNT_W-1:0]   gap_q, gap_d;
  logic                   pick_found_c;
  logic [IDX_W-1:0]       pick_idx_c;

`ifdef BIST_SCHED_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT);
  logic [WD_W-1:0]        wd_q, wd_d;
  logic [NUM_MEM-1:0]     tmo_q, tmo_d;
`endif

  bist_sched_pick #(
    .NUM_MEM (NUM_MEM),
    .IDX_W   (IDX_W)
  ) u_pick (
    .mask_i  (mask_q),
    .base_i  (base_q),
    .found_c (pick_found_c),
    .idx_c   (pick_idx_c)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      base_q  <= '0;
      sel_q   <= '0;
      eng_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= '0;
      allp_q  <= 1'b1;
      gap_q   <= '0;
`ifdef BIST_SCHED_TIMEOUT_EN
      wd_q    <= '0;
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      base_q  <= base_d;
      sel_q   <= sel_d;
      eng_q   <= eng_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      allp_q  <= ~|fail_d;
      gap_q   <= gap_d;
`ifdef BIST_SCHED_TIMEOUT_EN
      wd_q    <= wd_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  // Sweep sequencing: next state and next register values.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    base_d  = base_q;
    sel_d   = sel_q;
    eng_d   = eng_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    fail_d  = fail_q;
    gap_d   = gap_q;
`ifdef BIST_SCHED_TIMEOUT_EN
    wd_d    = wd_q;
    tmo_d   = tmo_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          mask_d  = bus.mem_mask;
          fail_d  = '0;
`ifdef BIST_SCHED_TIMEOUT_EN
          tmo_d   = '0;
`endif
          busy_d  = 1'b1;
          base_d  = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (pick_found_c) begin
          sel_d   = pick_idx_c;
          eng_d   = 1'b1;
`ifdef BIST_SCHED_TIMEOUT_EN
          wd_d    = '0;
`endif
          state_d = ST_RUN;
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_FINISH;
        end
      end
      ST_RUN: begin
        if (!bus.eng_pass) fail_d[sel_q] = 1'b1;
        if (bus.eng_done) begin
          eng_d   = 1'b0;
          gap_d   = '0;
          state_d = ST_DRAIN;
        end
`ifdef BIST_SCHED_TIMEOUT_EN
        else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          fail_d[sel_q] = 1'b1;
          tmo_d[sel_q]  = 1'b1;
          eng_d         = 1'b0;
          gap_d         = '0;
          state_d       = ST_DRAIN;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end
      ST_DRAIN: begin
        // Gap cycles only count once the engine has released done.
        if (!bus.eng_done) begin
          if (gap_q == GAP_CNT_W'(GAP - 1)) begin
            if (sel_q == IDX_W'(NUM_MEM - 1)) begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = ST_FINISH;
            end else begin
              base_d  = sel_q + IDX_W'(1);
              state_d = ST_SCAN;
            end
          end else begin
            gap_d = gap_q + GAP_CNT_W'(1);
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign bus.eng_start = eng_q;
  assign bus.mem_sel   = sel_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.fail_map  = fail_q;
  assign bus.all_pass  = allp_q;
`ifdef BIST_SCHED_TIMEOUT_EN
  assign bus.timeout_map = tmo_q;
`else
  assign bus.timeout_map = '0;
`endif

endmodule

// File: tb/tb_bist_sched.sv
// Bench for bist_sched: engine model, queue-based reference model checked
// every cycle, and directed sweeps with literal expectations.
module tb_bist_sched;
  import bist_sched_pkg::*;

  localparam int NM    = 4;
  localparam int GAP_P = 2;
`ifdef BIST_SCHED_TIMEOUT_EN
  localparam int TMO   = 64;
`else
  localparam int TMO   = 1024;
`endif
  localparam int DONE_LAT = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bist_sched_if #(.NUM_MEM(NM)) bus ();

  bist_sched #(
    .NUM_MEM (NM),
    .GAP     (GAP_P),
    .TIMEOUT (TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Engine model: done DONE_LAT cycles into a session, optional fail/hang.
  int eng_cnt  = 0;
  int fail_idx = -1;
  int fail_cyc = 0;
  int hang_idx = -1;
  always @(negedge clk) begin
    if (!rst_n || !bus.eng_start) begin
      eng_cnt      = 0;
      bus.eng_done = 1'b0;
      bus.eng_pass = 1'b1;
    end else begin
      eng_cnt++;
      if (int'(bus.mem_sel) == fail_idx && eng_cnt >= fail_cyc) bus.eng_pass = 1'b0;
      if (eng_cnt >= DONE_LAT && int'(bus.mem_sel) != hang_idx) bus.eng_done = 1'b1;
    end
  end

  // Reference model: pending enabled indices kept in a queue.
  int       pend[$];
  bit       m_eng, m_busy, m_done, m_scan, m_finish;
  int       m_sel, m_gap, m_wd;
  logic [NM-1:0] m_fail, m_tmo;

  function automatic void end_sweep();
    m_busy   = 1'b0;
    m_done   = 1'b1;
    m_finish = 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_eng = 0; m_busy = 0; m_done = 0; m_scan = 0; m_finish = 0;
      m_sel = 0; m_gap = 0; m_wd = 0; m_fail = '0; m_tmo = '0;
      pend.delete();
    end else begin
      m_done = 1'b0;
      if (m_finish) begin
        m_finish = 1'b0;
      end else if (!m_busy) begin
        if (bus.start) begin
          pend.delete();
          for (int i = 0; i < NM; i++) if (bus.mem_mask[i]) pend.push_back(i);
          m_fail = '0; m_tmo = '0; m_busy = 1'b1; m_scan = 1'b1;
        end
      end else if (m_scan) begin
        m_scan = 1'b0;
        if (pend.size() == 0) end_sweep();
        else begin
          m_sel = pend.pop_front();
          m_eng = 1'b1;
          m_wd  = 0;
        end
      end else if (m_eng) begin
        if (!bus.eng_pass) m_fail[m_sel] = 1'b1;
        if (bus.eng_done) begin
          m_eng = 1'b0; m_gap = 0;
        end
`ifdef BIST_SCHED_TIMEOUT_EN
        else if (m_wd == TMO - 1) begin
          m_fail[m_sel] = 1'b1; m_tmo[m_sel] = 1'b1; m_eng = 1'b0; m_gap = 0;
        end else m_wd++;
`endif
      end else if (!bus.eng_done) begin
        m_gap++;
        if (m_gap == GAP_P) begin
          if (m_sel == NM - 1) end_sweep();
          else m_scan = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus session logging.
  int  sess[$];
  int  sess_len[$];
  int  run_len  = 0;
  int  done_cnt = 0;
  bit  prev_eng = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("eng_start",   32'(bus.eng_start),   32'(m_eng));
      chk("mem_sel",     32'(bus.mem_sel),     32'(m_sel));
      chk("busy",        32'(bus.busy),        32'(m_busy));
      chk("done",        32'(bus.done),        32'(m_done));
      chk("fail_map",    32'(bus.fail_map),    32'(m_fail));
      chk("all_pass",    32'(bus.all_pass),    32'(m_fail == '0));
      chk("timeout_map", 32'(bus.timeout_map), 32'(m_tmo));
      if (bus.eng_start && !prev_eng) sess.push_back(int'(bus.mem_sel));
      if (bus.eng_start) run_len = prev_eng ? run_len + 1 : 1;
      if (!bus.eng_start && prev_eng) sess_len.push_back(run_len);
      if (bus.done) done_cnt++;
      prev_eng = bus.eng_start;
    end else begin
      prev_eng = 1'b0;
    end
  end

  task automatic clear_logs();
    sess.delete();
    sess_len.delete();
    done_cnt = 0;
  endtask

  task automatic kick(input logic [NM-1:0] m);
    bus.mem_mask = m;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int n = 0;
    while (bus.done !== 1'b1 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, 32'(bus.done), 32'd1);
  endtask

  task automatic wait_sel(input string tag, input int k, input int max_cyc);
    int n = 0;
    while (!(bus.eng_start === 1'b1 && int'(bus.mem_sel) == k) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_sel_seen"}, 32'(n < max_cyc), 32'd1);
  endtask

  task automatic chk_sess(input string tag, input int n, input int e0, input int e1,
                          input int e2, input int e3);
    int e[4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    chk({tag, "_nsess"}, 32'(sess.size()), 32'(n));
    for (int i = 0; i < n && i < sess.size(); i++)
      chk($sformatf("%s_sess%0d", tag, i), 32'(sess[i]), 32'(e[i]));
  endtask

  function automatic int len_at(input int i);
    return (i < sess_len.size()) ? sess_len[i] : -1;
  endfunction

  initial begin
    bus.start    = 1'b0;
    bus.mem_mask = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_eng_start", 32'(bus.eng_start), 32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_mem_sel",   32'(bus.mem_sel),   32'd0);
    chk("rst_fail_map",  32'(bus.fail_map),  32'd0);
    chk("rst_all_pass",  32'(bus.all_pass),  32'd1);

    // Full sweep, all passing; start-to-engine latency pinned.
    clear_logs();
    kick(4'b1111);
    chk("t1_lat_eng_lo", 32'(bus.eng_start), 32'd0);
    chk("t1_lat_busy",   32'(bus.busy),      32'd1);
    @(negedge clk);
    chk("t1_lat_eng_hi", 32'(bus.eng_start), 32'd1);
    chk("t1_lat_sel",    32'(bus.mem_sel),   32'd0);
    wait_done("t1", 1000);
    chk("t1_fail_map", 32'(bus.fail_map), 32'h0);
    chk("t1_all_pass", 32'(bus.all_pass), 32'd1);
    @(negedge clk);
    chk_sess("t1", 4, 0, 1, 2, 3);
    chk("t1_len0",     32'(len_at(0)), 32'(DONE_LAT));
    chk("t1_len3",     32'(len_at(3)), 32'(DONE_LAT));
    chk("t1_done_cnt", 32'(done_cnt),  32'd1);

    // Empty mask: done exactly two cycles after the start pulse.
    clear_logs();
    kick(4'b0000);
    chk("t2_done_c1", 32'(bus.done), 32'd0);
    @(negedge clk);
    chk("t2_done_c2", 32'(bus.done),     32'd1);
    chk("t2_busy",    32'(bus.busy),     32'd0);
    chk("t2_allpass", 32'(bus.all_pass), 32'd1);
    @(negedge clk);
    chk("t2_done_c3", 32'(bus.done), 32'd0);
    chk("t2_nsess",   32'(sess.size()), 32'd0);

    // Sparse mask with a late failure on the last instance.
    clear_logs();
    fail_idx = 3; fail_cyc = 10;
    kick(4'b1010);
    wait_done("t3", 1000);
    chk("t3_fail_map", 32'(bus.fail_map), 32'h8);
    chk("t3_all_pass", 32'(bus.all_pass), 32'd0);
    chk_sess("t3", 2, 1, 3, 0, 0);
    fail_idx = -1;
    @(negedge clk);

    // Start and mask change mid-sweep, start during FINISH: all ignored.
    clear_logs();
    kick(4'b1111);
    wait_sel("t4", 1, 500);
    repeat (5) @(negedge clk);
    bus.mem_mask = 4'b0001;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    wait_done("t4", 1000);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("t4_busy_after", 32'(bus.busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("t4_busy_late", 32'(bus.busy), 32'd0);
    chk("t4_done_cnt",  32'(done_cnt),  32'd1);
    chk_sess("t4", 4, 0, 1, 2, 3);

    // Asynchronous reset in the middle of instance 2's session.
    clear_logs();
    fail_idx = 1; fail_cyc = 5;
    kick(4'b1111);
    wait_sel("t5", 2, 500);
    repeat (3) @(negedge clk);
    chk("t5_pre_fail", 32'(bus.fail_map), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_eng",  32'(bus.eng_start), 32'd0);
    chk("t5_rst_busy", 32'(bus.busy),      32'd0);
    chk("t5_rst_fail", 32'(bus.fail_map),  32'h0);
    chk("t5_rst_sel",  32'(bus.mem_sel),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    fail_idx = -1;
    @(negedge clk);
    clear_logs();
    kick(4'b0011);
    wait_done("t5", 1000);
    chk("t5_fail_map", 32'(bus.fail_map), 32'h0);
    @(negedge clk);
    chk_sess("t5", 2, 0, 1, 0, 0);
    chk("t5_done_cnt", 32'(done_cnt), 32'd1);

`ifdef BIST_SCHED_TIMEOUT_EN
    // Engine hangs on instance 1: watchdog drops it, sweep continues.
    clear_logs();
    hang_idx = 1;
    kick(4'b0110);
    wait_done("t6", 2000);
    chk("t6_tmo_map",  32'(bus.timeout_map), 32'h2);
    chk("t6_fail_map", 32'(bus.fail_map),    32'h2);
    @(negedge clk);
    chk_sess("t6", 2, 1, 2, 0, 0);
    chk("t6_len_hang", 32'(len_at(0)), 32'(TMO));
    chk("t6_len_next", 32'(len_at(1)), 32'(DONE_LAT));
    hang_idx = -1;
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
